div8_seq_ctrl: RTL and testbench

//  Multi-cycle unsigned 8-bit restoring divider controller.
//  - Sequences a single shared RCA8 subtract datapath: ~divisor fed in, cin=1.
//  - Produces quotient and remainder over WIDTH iterations, one quotient bit per cycle.
//  - Sits beside the ALU subtract path; a start/busy/done handshake lets a host issue divides.

---
 rtl/div8_pkg.sv | 20 ++
 rtl/div8_step.sv | 36 +++
 rtl/rca8.sv | 30 +++
 rtl/div8_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_div8_seq_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/div8_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div8_pkg
// Brief   : Shared constants and state encoding for the sequential divider.
// Revision: 1.0
// ============================================================================
package div8_pkg;

    localparam int DIV_W = 8;
    localparam int CNT_W = 3;

    localparam logic [DIV_W-1:0] DBZ_QUOT = 8'hFF;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/div8_step.sv
`default_nettype none
// ============================================================================
// Module  : div8_step
// Brief   : One restoring-division iteration built on the shared RCA8.
// Revision: 1.0
// ============================================================================
module div8_step
    import div8_pkg::*;
(
    input  logic [DIV_W-1:0] r_i,
    input  logic [DIV_W-1:0] q_i,
    input  logic [DIV_W-1:0] divisor_i,
    output logic [DIV_W-1:0] r_o,
    output logic [DIV_W-1:0] q_o
);

    logic [DIV_W-1:0] shifted;
    logic [DIV_W-1:0] diff;
    logic             no_borrow;

    // R stays below the divisor (<=127), so dropping R[7] on the shift loses nothing.
    assign shifted = {r_i[DIV_W-2:0], q_i[DIV_W-1]};

    rca8 u_rca8 (
        .a_i    (shifted),
        .b_i    (~divisor_i),
        .cin_i  (1'b1),
        .sum_o  (diff),
        .cout_o (no_borrow)
    );

    assign r_o = no_borrow ? diff : shifted;
    assign q_o = {q_i[DIV_W-2:0], no_borrow};

endmodule
`default_nettype wire

// File: rtl/rca8.sv
`default_nettype none
// ============================================================================
// Module  : rca8
// Brief   : Fixed-width 8-bit ripple-carry adder.
// Revision: 1.0
// ============================================================================
module rca8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);

    logic [8:0] carry;

    assign carry[0] = cin_i;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_bit
            assign sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
            assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    endgenerate

    assign cout_o = carry[8];

endmodule
`default_nettype wire

// File: rtl/div8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : div8_seq_ctrl
// Brief   : Multi-cycle unsigned 8-bit restoring divider with start/busy/done.
// Revision: 1.0
// ============================================================================
module div8_seq_ctrl
    import div8_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    generate
        if (WIDTH != 8) begin : g_width_chk
            $error("div8_seq_ctrl: WIDTH must be 8, the RCA8 datapath is fixed-width");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] part_q, part_d;
    logic [DIV_W-1:0] shq_q, shq_d;
    logic [DIV_W-1:0] dvsr_q, dvsr_d;
    logic [DIV_W-1:0] quot_q, quot_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [DIV_W-1:0] step_r;
    logic [DIV_W-1:0] step_q;
    logic             accept;
    logic             dvsr_zero;

    assign accept    = start && ((state_q == S_IDLE) || (state_q == S_FIN));
    assign dvsr_zero = (divisor == '0);

    div8_step u_step (
        .r_i       (part_q),
        .q_i       (shq_q),
        .divisor_i (dvsr_q),
        .r_o       (step_r),
        .q_o       (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (start) begin
                    state_d = dvsr_zero ? S_FIN : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_FIN);
    end

    // Results only move on an accepted start (divide-by-zero) or the last RUN step.
    always_comb begin
        cnt_d  = cnt_q;
        part_d = part_q;
        shq_d  = shq_q;
        dvsr_d = dvsr_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        if (accept) begin
            dbz_d = dvsr_zero;
            if (dvsr_zero) begin
                quot_d = DBZ_QUOT;
                rem_d  = dividend;
            end else begin
                dvsr_d = divisor;
                part_d = '0;
                shq_d  = dividend;
                cnt_d  = '0;
            end
        end else if (state_q == S_RUN) begin
            part_d = step_r;
            shq_d  = step_q;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                quot_d = step_q;
                rem_d  = step_r;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            part_q <= '0;
            shq_q  <= '0;
            dvsr_q <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            part_q <= part_d;
            shq_q  <= shq_d;
            dvsr_q <= dvsr_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_div8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_div8_seq_ctrl
// Brief   : Directed and scoreboard checks for div8_seq_ctrl.
// Revision: 1.0
// ============================================================================
module tb_div8_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    div8_seq_ctrl #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a start for one edge; returns #1 after the accepting edge.
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
    endtask

    // Waits for done; exp_lat is the number of further edges until done is seen.
    task automatic finish_div(input logic [7:0] a, input logic [7:0] b, input int exp_lat,
                              input string tag, input bit chk_pulse);
        int         cycles;
        int         busy_n;
        bit         stable;
        logic [7:0] q0;
        logic [7:0] r0;
        cycles = 0;
        busy_n = 0;
        stable = 1'b1;
        q0     = quotient;
        r0     = remainder;
        while (!done && cycles < 20) begin
            if (busy) busy_n++;
            if (quotient !== q0 || remainder !== r0) stable = 1'b0;
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, " latency"}, cycles, exp_lat);
        check({tag, " busy_cycles"}, busy_n, exp_lat);
        check({tag, " busy_at_done"}, busy, 0);
        if (b != 0) check({tag, " held_in_run"}, stable, 1);
        check({tag, " quotient"}, quotient, (b == 0) ? 8'hFF : a / b);
        check({tag, " remainder"}, remainder, (b == 0) ? a : a % b);
        check({tag, " dbz"}, div_by_zero, (b == 0));
        if (chk_pulse) begin
            @(posedge clk);
            #1;
            check({tag, " done_pulse"}, done, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  seen;
        logic [7:0] ra;
        logic [7:0] rb;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (2) @(posedge clk);
        #2;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst quotient", quotient, 0);
        check("rst remainder", remainder, 0);
        check("rst dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: basic divide with latency
        launch(8'd100, 8'd7);
        check("t1 busy_after_accept", busy, 1);
        finish_div(8'd100, 8'd7, 8, "t1_100_7", 1'b1);

        // 2: boundary operands
        launch(8'd255, 8'd1);   finish_div(8'd255, 8'd1,   8, "t2_255_1",   1'b1);
        launch(8'd5,   8'd9);   finish_div(8'd5,   8'd9,   8, "t2_5_9",     1'b1);
        launch(8'd200, 8'd200); finish_div(8'd200, 8'd200, 8, "t2_200_200", 1'b1);

        // 3: divide by zero, then a normal divide clears the flag
        launch(8'd37, 8'd0);    finish_div(8'd37, 8'd0, 0, "t3_37_0", 1'b1);
        launch(8'd10, 8'd3);    finish_div(8'd10, 8'd3, 8, "t3_10_3", 1'b1);

        // 4: back-to-back accept from FIN
        launch(8'd100, 8'd7);
        finish_div(8'd100, 8'd7, 8, "t4_first", 1'b0);
        dividend = 8'd50;
        divisor  = 8'd6;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        check("t4 no_idle_bubble", busy, 1);
        finish_div(8'd50, 8'd6, 8, "t4_50_6", 1'b1);

        // 5: start during RUN is ignored
        launch(8'd100, 8'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        dividend = 8'd3;
        divisor  = 8'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        finish_div(8'd100, 8'd7, 4, "t5_ignore", 1'b1);
        check("t5 idle_after", busy, 0);

        // 6: asynchronous reset mid-RUN
        launch(8'd200, 8'd3);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t6 busy", busy, 0);
        check("t6 done", done, 0);
        check("t6 quotient", quotient, 0);
        check("t6 remainder", remainder, 0);
        check("t6 dbz", div_by_zero, 0);
        #2;
        rst  = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check("t6 no_done_after_abort", seen, 0);
        launch(8'd9, 8'd2);
        finish_div(8'd9, 8'd2, 8, "t6_9_2", 1'b1);

        // scoreboard with random operands, divisor 0 included
        for (int k = 0; k < 24; k++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            launch(ra, rb);
            finish_div(ra, rb, (rb == 0) ? 0 : 8, $sformatf("rnd%0d_%0d_%0d", k, ra, rb), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
